sub_nbit_bout_serial: RTL

//   Digit-serial n-bit subtractor with borrow out: Diff = A - B (mod 2^WIDTH), Bout = (A < B) unsigned.
//   It is the inverse of the ripple n-bit adder with carry out. The datapath is DIGIT adder_1bit cells, fed with ~B.

---
 rtl/sub_nbit_bout_serial.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sub_nbit_bout_serial.sv
// Digit-serial subtractor: Diff = A - B mod 2^WIDTH, Bout = (A < B), DIGIT bits per cycle.
// Optional signed-overflow output Ovf is enabled by defining SUB_SERIAL_OVF_EN.

module adder_1bit #(
  parameter int IMPL_TYPE = 0
) (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  generate
    if (IMPL_TYPE == 0) begin : g_gate
      assign o_sum  = i_a ^ i_b ^ i_cin;
      assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
    end else begin : g_arith
      assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {1'b0, i_cin};
    end
  endgenerate

endmodule

module sub_nbit_bout_serial #(
  parameter int WIDTH     = 32,
  parameter int DIGIT     = 1,
  parameter int IMPL_TYPE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef SUB_SERIAL_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if ((WIDTH % DIGIT) != 0) begin : g_width_check
      $error("sub_nbit_bout_serial: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic               r_out_valid;
  logic               r_bout;
`ifdef SUB_SERIAL_OVF_EN
  logic               r_a_msb;
  logic               r_b_msb;
  logic               r_ovf;
`endif

  logic [DIGIT:0]     w_carry;
  logic [DIGIT-1:0]   w_sum;
  logic [DIGIT-1:0]   w_bn;
  logic [WIDTH-1:0]   w_res_next;
  logic               w_accept;
  logic               w_last;

  assign in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == CNT_W'(NDIG - 1));

  // Subtraction as A + ~B + 1: the carry register starts at 1 for the low digit.
  assign w_bn       = ~r_b[DIGIT-1:0];
  assign w_carry[0] = r_carry;

  generate
    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
      adder_1bit #(.IMPL_TYPE(IMPL_TYPE)) u_cell (
        .i_a    (r_a[i]),
        .i_b    (w_bn[i]),
        .i_cin  (w_carry[i]),
        .o_sum  (w_sum[i]),
        .o_cout (w_carry[i+1])
      );
    end

    if (DIGIT == WIDTH) begin : g_res_full
      assign w_res_next = w_sum;
    end else begin : g_res_shift
      assign w_res_next = {w_sum, r_res[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_carry     <= 1'b1;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_out_valid <= 1'b0;
      r_bout      <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
      r_a_msb     <= 1'b0;
      r_b_msb     <= 1'b0;
      r_ovf       <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state     <= RUN;
      r_cnt       <= '0;
      r_carry     <= 1'b1;
      r_a         <= A;
      r_b         <= B;
      r_out_valid <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
      r_a_msb     <= A[WIDTH-1];
      r_b_msb     <= B[WIDTH-1];
`endif
    end else if (r_state == RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_res   <= w_res_next;
      r_carry <= w_carry[DIGIT];
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_state     <= DONE;
        r_out_valid <= 1'b1;
        r_bout      <= ~w_carry[DIGIT];
`ifdef SUB_SERIAL_OVF_EN
        r_ovf       <= (r_a_msb != r_b_msb) && (w_sum[DIGIT-1] != r_a_msb);
`endif
      end
    end else if ((r_state == DONE) && out_ready) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign Diff      = r_res;
  assign Bout      = r_bout;
`ifdef SUB_SERIAL_OVF_EN
  assign Ovf       = r_ovf;
`endif

endmodule
